// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - idle-driven clock-gate enable controller with quiesce handshake and timed wake.
// Optional gate-event counter enabled by defining CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
  parameter int IdleCntWidth = 8,
  parameter int WakeCycles   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [IdleCntWidth-1:0] idle_thresh_i,
  input  logic                    busy_i,
  input  logic                    wake_i,
  input  logic                    force_on_i,
  input  logic                    quiesce_ack_i,
  output logic                    quiesce_req_o,
  output logic                    clk_en_o,
  output logic                    clk_ready_o,
  output logic                    gated_o
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [15:0]             gate_events_o
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_QUIESCE, ST_GATED, ST_WAKE} state_e;

  localparam int WcW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
  localparam logic [WcW-1:0]          WakeLast = WcW'(WakeCycles - 1);
  localparam logic [IdleCntWidth-1:0] CntMax   = '1;

  state_e                  r_state, w_state_nxt;
  logic [IdleCntWidth-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [WcW-1:0]          r_wake_cnt, w_wake_cnt_nxt;
  logic [IdleCntWidth-1:0] w_thresh_m1;
  logic                    w_idle;

  logic r_clk_en, r_clk_ready, r_quiesce_req, r_gated;

  assign w_idle      = !busy_i && !force_on_i;
  assign w_thresh_m1 = idle_thresh_i - IdleCntWidth'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    case (r_state)
      ST_RUN: begin
        if ((idle_thresh_i == '0) || !w_idle) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == w_thresh_m1) begin
          // An unclosed previous handshake (ack still high) holds the count at threshold.
          if (!quiesce_ack_i) begin
            w_state_nxt    = ST_QUIESCE;
            w_idle_cnt_nxt = '0;
          end
        end else if (r_idle_cnt != CntMax) begin
          w_idle_cnt_nxt = r_idle_cnt + IdleCntWidth'(1);
        end
      end
      ST_QUIESCE: begin
        if (busy_i || wake_i || force_on_i) begin
          w_state_nxt    = ST_RUN;
          w_idle_cnt_nxt = '0;
        end else if (quiesce_ack_i) begin
          w_state_nxt = ST_GATED;
        end
      end
      ST_GATED: begin
        if (wake_i || force_on_i) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = '0;
        end
      end
      ST_WAKE: begin
        if (r_wake_cnt == WakeLast) begin
          w_state_nxt    = ST_RUN;
          w_idle_cnt_nxt = '0;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt + WcW'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_RUN;
      r_idle_cnt    <= '0;
      r_wake_cnt    <= '0;
      r_clk_en      <= 1'b1;
      r_clk_ready   <= 1'b1;
      r_quiesce_req <= 1'b0;
      r_gated       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_wake_cnt    <= w_wake_cnt_nxt;
      r_clk_en      <= (w_state_nxt != ST_GATED);
      r_clk_ready   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_QUIESCE);
      r_quiesce_req <= (w_state_nxt == ST_QUIESCE) || (w_state_nxt == ST_GATED);
      r_gated       <= (w_state_nxt == ST_GATED);
    end
  end

  assign clk_en_o      = r_clk_en;
  assign clk_ready_o   = r_clk_ready;
  assign quiesce_req_o = r_quiesce_req;
  assign gated_o       = r_gated;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] r_gate_events;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gate_events <= '0;
    end else if ((r_state == ST_QUIESCE) && (w_state_nxt == ST_GATED) &&
                 (r_gate_events != 16'hFFFF)) begin
      r_gate_events <= r_gate_events + 16'd1;
    end
  end

  assign gate_events_o = r_gate_events;
`endif

endmodule
